// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: datapath widths, coin values and FSM encodings.
package change_dispenser_pkg;

   localparam int TOTAL_BITS = 14;
   localparam int NUM_COINS  = 3;

   typedef logic [TOTAL_BITS-1:0] amount_t;
   typedef logic [NUM_COINS-1:0]  coin_t;

   localparam amount_t COIN_VALUE0 = 14'd100;
   localparam amount_t COIN_VALUE1 = 14'd500;
   localparam amount_t COIN_VALUE2 = 14'd1000;

   typedef enum logic [1:0] {
      DISP_IDLE = 2'd0,
      DISP_RUN  = 2'd1,
      DISP_DONE = 2'd2
   } disp_state_t;

   // Face value of a one-hot denomination; zero when no coin is selected.
   function automatic amount_t coin_value(input coin_t sel);
      amount_t value;
      case (sel)
         3'b001:  value = COIN_VALUE0;
         3'b010:  value = COIN_VALUE1;
         3'b100:  value = COIN_VALUE2;
         default: value = 14'd0;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/hopper handshake bundle between the vending controller and the change dispenser.
interface change_dispenser_if;
   import change_dispenser_pkg::*;

   logic    i_trigger_return;
   amount_t i_total;
   logic    i_coin_ready;
   logic    o_coin_valid;
   coin_t   o_coin;
   logic    o_busy;
   logic    o_done;
   amount_t o_remaining;
   logic    o_timeout;

   modport master (
      output i_trigger_return, i_total, i_coin_ready,
      input  o_coin_valid, o_coin, o_busy, o_done, o_remaining, o_timeout
   );

   modport slave (
      input  i_trigger_return, i_total, i_coin_ready,
      output o_coin_valid, o_coin, o_busy, o_done, o_remaining, o_timeout
   );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy denomination picker: largest coin whose value does not exceed the remaining amount.
module change_dispenser_coin_select
   import change_dispenser_pkg::*;
(
   input  amount_t remaining,
   output coin_t   sel,
   output amount_t value,
   output logic    has_coin
);

   // Priority compare from the largest denomination down.
   always_comb begin
      sel = 3'b000;
      if (remaining >= COIN_VALUE2) begin
         sel = 3'b100;
      end else if (remaining >= COIN_VALUE1) begin
         sel = 3'b010;
      end else if (remaining >= COIN_VALUE0) begin
         sel = 3'b001;
      end else begin
         sel = 3'b000;
      end
      value    = coin_value(sel);
      has_coin = (sel != 3'b000);
   end

endmodule

// File: rtl/change_dispenser.sv
// Pays back the latched total as a greedy coin sequence over a valid/ready hopper handshake.
// Optional stall abort is built only when DISPENSE_TIMEOUT_EN is defined.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                reset_n,
   change_dispenser_if.slave   bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   disp_state_t state_q, state_d;
   amount_t     remaining_q, remaining_d;
   coin_t       sel;
   amount_t     sel_value;
   logic        has_coin;

`ifdef DISPENSE_TIMEOUT_EN
   localparam int STALL_BITS = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_BITS-1:0] stall_q, stall_d;
   logic                  timeout_q, timeout_d;
`endif

   change_dispenser_coin_select u_coin_select (
      .remaining (remaining_q),
      .sel       (sel),
      .value     (sel_value),
      .has_coin  (has_coin)
   );

   // Next-state and datapath update; leaves DISPENSE on the fire that drops remaining below 100.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
`ifdef DISPENSE_TIMEOUT_EN
      stall_d     = stall_q;
      timeout_d   = timeout_q;
`endif
      case (state_q)
         DISP_IDLE: begin
            if (bus.i_trigger_return) begin
               state_d     = DISP_RUN;
               remaining_d = bus.i_total;
`ifdef DISPENSE_TIMEOUT_EN
               stall_d     = {STALL_BITS{1'b0}};
               timeout_d   = 1'b0;
`endif
            end else begin
               state_d = DISP_IDLE;
            end
         end
         DISP_RUN: begin
            if (!has_coin) begin
               state_d = DISP_DONE;
            end else if (bus.i_coin_ready) begin
               remaining_d = remaining_q - sel_value;
               state_d     = (remaining_d < COIN_VALUE0) ? DISP_DONE : DISP_RUN;
`ifdef DISPENSE_TIMEOUT_EN
               stall_d     = {STALL_BITS{1'b0}};
`endif
            end else begin
`ifdef DISPENSE_TIMEOUT_EN
               if (stall_q == STALL_BITS'(TIMEOUT_CYCLES - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = DISP_DONE;
                  stall_d   = {STALL_BITS{1'b0}};
               end else begin
                  stall_d   = stall_q + {{(STALL_BITS-1){1'b0}}, 1'b1};
               end
`else
               state_d = DISP_RUN;
`endif
            end
         end
         DISP_DONE: begin
            state_d = DISP_IDLE;
         end
         default: begin
            state_d = DISP_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= DISP_IDLE;
         remaining_q <= 14'd0;
`ifdef DISPENSE_TIMEOUT_EN
         stall_q     <= {STALL_BITS{1'b0}};
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
`ifdef DISPENSE_TIMEOUT_EN
         stall_q     <= stall_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   // Coin selection reads registered remaining, so the offer holds steady through a stall.
   assign bus.o_coin_valid = (state_q == DISP_RUN) && has_coin;
   assign bus.o_coin       = bus.o_coin_valid ? sel : 3'b000;
   assign bus.o_busy       = (state_q != DISP_IDLE);
   assign bus.o_done       = (state_q == DISP_DONE);
   assign bus.o_remaining  = remaining_q;
`ifdef DISPENSE_TIMEOUT_EN
   assign bus.o_timeout    = timeout_q;
`else
   assign bus.o_timeout    = 1'b0;
`endif

endmodule
